bit_slot_deserializer: RTL and testbench
========================================

Name: bit_slot_deserializer

Overview:
Serial-in, parallel-out assembler. It is the inverse of the team's sel-indexed 4:1 bit mux. It accepts one bit per valid/ready handshake and writes it into slot `slot_idx` of an assembly register. Once all WIDTH slots are filled it presents the word on a valid/ready output with a one-word holding register. It sits at the receive end of bit-serial links, reconstructing words that a mux-based serializer emitted slot by slot.

Parameters:
WIDTH, 4, word width in bits (number of slots), >= 2
SEL_W, $clog2(WIDTH), width of slot index
MSB_FIRST, 0, 0: slot k writes bit k; 1: slot k writes bit WIDTH-1-k

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  sync clear; discards the partial word
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in is valid
bit_ready  out  1  block accepts bit this cycle
slot_idx  out  SEL_W  slot the next accepted bit will fill (mirror of mux sel)
data_out  out  WIDTH  assembled word
data_valid  out  1  data_out holds a complete word
data_ready  in  1  downstream consumes the word

Behaviour:
- Reset (async assert, sync release):
  - slot_idx = 0, assembly register = 0, data_out = 0, data_valid = 0, output FSM = OUT_EMPTY.
  - bit_ready = 0 while rst_n is low.
- Bit accept: bit_valid && bit_ready at a rising edge. The bit is written into the assembly slot mapped from slot_idx; slot_idx then increments.
- Wrap: an accept at slot_idx == WIDTH-1 sets slot_idx to 0. The full word (including the bit just accepted) loads into data_out, and data_valid goes to 1 on the next cycle (latency 1 from the last bit's handshake). The assembly register clears to 0 on the same edge.
- Output FSM:
  - OUT_EMPTY -> OUT_FULL on a word load.
  - OUT_FULL -> OUT_EMPTY on data_ready with no simultaneous load.
  - OUT_FULL stays OUT_FULL on data_ready plus a simultaneous load (back-to-back; the new word replaces the old one on the same edge).
  - data_valid = (state == OUT_FULL).
- bit_ready = !clear && (slot_idx != WIDTH-1 || !data_valid || data_ready). Bits for non-final slots are always accepted, even while a word is held. Only the final bit stalls, when the holding register is full and not draining. This is combinational, with no dependency on bit_valid.
- data_out and data_valid stay stable while data_valid && !data_ready; no word is lost or overwritten.
- clear:
  - slot_idx resets to 0 and the assembly register to 0; a bit presented in the same cycle is not accepted (clear wins).
  - The held output word and data_valid are unaffected; data_ready is still honoured in that cycle.
- Mid-operation reset: all state returns to reset values immediately, and any partial or held word is lost.
- Throughput: one bit per cycle sustained when data_ready = 1, i.e. one word every WIDTH cycles with no bubbles.
- Non-handshake cycles (bit_valid = 0) leave slot_idx and the assembly register unchanged.

Decomposition:
- Shared package: `out_state_t` enum {OUT_EMPTY, OUT_FULL}, and the DEFAULT_WIDTH constant (4) shared with the serializer-side mux.
- One sub-module is natural: `slot_counter`.
  - Parameter WIDTH.
  - Inputs: clk, rst_n, clear, inc.
  - Outputs: idx[SEL_W] and last (idx == WIDTH-1).
  - Behaviour: modulo-WIDTH counter, sync clear, async reset.
- Top level holds the assembly register, the output register and the FSM.

Test Plan:
- Basic LSB-first: after reset, send bits 0,1,0,1 with bit_valid=1 and data_ready=1 -> slot_idx steps 0,1,2,3,0. data_valid=1 one cycle after the 4th accept, data_out=4'b1010.
- MSB_FIRST=1: send 1,0,1,0 -> data_out=4'b1010. Check that slot 0 wrote bit 3.
- Backpressure: data_ready=0, send 8 bits (word A=4'b1010, word B=4'b0110) continuously.
  - bit_ready drops only at slot 3 of word B, and data_out holds 4'b1010 stable.
  - Raise data_ready for one cycle -> the final bit of B is accepted that cycle, A is consumed, and data_out=4'b0110 the next cycle.
- Back-to-back: data_ready=1, 12 consecutive valid bits -> three words, each data_valid pulse one cycle long, no stall cycles.
- clear: send 2 bits, then assert clear with bit_valid=1 -> bit not accepted, slot_idx=0. The next 4 bits 1,1,0,0 -> data_out=4'b0011, with no stale bits.
- Async reset: drop rst_n mid-word while data_valid=1 -> data_valid, data_out and slot_idx are all 0 immediately, with no clock edge required, and bit_ready=0 while rst_n is low.

Source files
------------

// File: rtl/bit_slot_deserializer_pkg.sv
// Shared definitions for the bit-slot deserializer and its serializer-side mux.
//   DEFAULT_WIDTH : default word width (number of slots), common to both ends
//   out_state_t   : state of the one-word output holding register
package bit_slot_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/bit_slot_deserializer_slot_counter.sv
// Modulo-WIDTH slot counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous clear to slot 0 (takes priority over inc)
//   inc   : advance to the next slot, wrapping WIDTH-1 -> 0
//   idx   : current slot
//   last  : idx == WIDTH-1
module slot_counter
    import bit_slot_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [SEL_W-1:0] idx,
    output logic             last
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/bit_slot_deserializer.sv
// Serial-in, parallel-out word assembler (inverse of the sel-indexed bit mux).
// One bit is accepted per bit_valid/bit_ready handshake and written into the
// slot given by slot_idx. The accept that fills the last slot loads the full
// word into a one-word holding register presented on data_valid/data_ready.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous discard of the partial word (held word kept)
//   bit_in     : serial data bit
//   bit_valid  : bit_in is valid
//   bit_ready  : a bit is accepted this cycle
//   slot_idx   : slot the next accepted bit fills
//   data_out   : assembled word
//   data_valid : data_out holds a complete word
//   data_ready : downstream consumes the word
module bit_slot_deserializer
    import bit_slot_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SEL_W-1:0] slot_idx,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready
);

    // Map a slot number to the bit position it fills in the word.
    function automatic logic [SEL_W-1:0] slot_to_bit(input logic [SEL_W-1:0] slot);
        if (MSB_FIRST) begin
            return SEL_W'(WIDTH - 1) - slot;
        end
        return slot;
    endfunction

    logic             slot_last;
    logic             accept;
    logic             word_done;
    logic [SEL_W-1:0] bit_pos;
    logic [WIDTH-1:0] asm_word_p0;
    logic [WIDTH-1:0] asm_next;
    logic [WIDTH-1:0] out_word_p1;
    out_state_t       state_p1;

    // Only the final bit can stall: it needs room in the holding register.
    // Gating with rst_n keeps bit_ready low for the whole reset interval.
    assign bit_ready = rst_n && !clear && (!slot_last || !data_valid || data_ready);
    assign accept    = bit_valid && bit_ready;
    assign word_done = accept && slot_last;
    assign bit_pos   = slot_to_bit(slot_idx);

    slot_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (accept),
        .idx   (slot_idx),
        .last  (slot_last)
    );

    // Assembly word including the bit being presented; on the final slot this
    // is the complete word loaded into the holding register.
    always_comb begin
        asm_next          = asm_word_p0;
        asm_next[bit_pos] = bit_in;
    end

    // Stage p0: assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_word_p0 <= '0;
        end else if (clear || word_done) begin
            asm_word_p0 <= '0;
        end else if (accept) begin
            asm_word_p0 <= asm_next;
        end
    end

    // Stage p1: output holding register and its FSM. A load only happens when
    // bit_ready allowed the final bit, so a held, undrained word is never
    // overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_p1 <= '0;
            state_p1    <= OUT_EMPTY;
        end else begin
            if (word_done) begin
                out_word_p1 <= asm_next;
            end
            case (state_p1)
                OUT_EMPTY: begin
                    if (word_done) begin
                        state_p1 <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (data_ready && !word_done) begin
                        state_p1 <= OUT_EMPTY;
                    end
                end
                default: state_p1 <= OUT_EMPTY;
            endcase
        end
    end

    assign data_out   = out_word_p1;
    assign data_valid = (state_p1 == OUT_FULL);

endmodule

// File: tb/tb_bit_slot_deserializer.sv
module tb_bit_slot_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;

    // LSB-first instance
    logic       clear;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [1:0] slot_idx;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;

    // MSB-first instance
    logic       m_clear;
    logic       m_bit_in;
    logic       m_bit_valid;
    logic       m_bit_ready;
    logic [1:0] m_slot_idx;
    logic [3:0] m_data_out;
    logic       m_data_valid;
    logic       m_data_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_slot_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .slot_idx   (slot_idx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    bit_slot_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (m_clear),
        .bit_in     (m_bit_in),
        .bit_valid  (m_bit_valid),
        .bit_ready  (m_bit_ready),
        .slot_idx   (m_slot_idx),
        .data_out   (m_data_out),
        .data_valid (m_data_valid),
        .data_ready (m_data_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leave the bench 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] words [3];
    logic [3:0] exp_b;

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        data_ready   = 1'b0;
        m_clear      = 1'b0;
        m_bit_in     = 1'b0;
        m_bit_valid  = 1'b0;
        m_data_ready = 1'b0;

        // ---- reset state ----
        #2;
        check_eq("rst_slot_idx", 32'(slot_idx), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_data_valid", 32'(data_valid), 32'd0);
        check_eq("rst_bit_ready", 32'(bit_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_bit_ready", 32'(bit_ready), 32'd1);

        // ---- basic LSB-first: bits 0,1,0,1 -> 4'b1010 ----
        data_ready = 1'b1;
        bit_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'(i & 1);
            #1;
            check_eq($sformatf("basic_slot_idx_%0d", i), 32'(slot_idx), 32'(i));
            tick();
        end
        bit_valid = 1'b0;
        check_eq("basic_slot_wrap", 32'(slot_idx), 32'd0);
        check_eq("basic_data_valid", 32'(data_valid), 32'd1);
        check_eq("basic_data_out", 32'(data_out), 32'hA);
        tick();
        check_eq("basic_consumed", 32'(data_valid), 32'd0);

        // ---- MSB-first: 1,0,1,0 -> 1010, then 1,0,0,0 -> 1000 ----
        m_data_ready = 1'b1;
        m_bit_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_bit_in = (i < 4) ? 1'(~i & 1) : 1'(i == 4);
            tick();
            if (i == 3) begin
                check_eq("msb_data_valid_a", 32'(m_data_valid), 32'd1);
                check_eq("msb_data_out_a", 32'(m_data_out), 32'hA);
            end
            if (i == 7) begin
                check_eq("msb_slot0_is_bit3", 32'(m_data_out), 32'h8);
            end
        end
        m_bit_valid = 1'b0;
        tick();

        // ---- backpressure: word A=1010, word B=0110, data_ready low ----
        words[0] = 4'b1010;
        words[1] = 4'b0110;
        data_ready = 1'b0;
        bit_valid  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bit_in = words[j / 4][j % 4];
            #1;
            check_eq($sformatf("bp_bit_ready_%0d", j), 32'(bit_ready), (j == 7) ? 32'd0 : 32'd1);
            if (j < 7) tick();
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("bp_hold_data_out", 32'(data_out), 32'hA);
            check_eq("bp_hold_valid", 32'(data_valid), 32'd1);
            check_eq("bp_hold_slot_idx", 32'(slot_idx), 32'd3);
            check_eq("bp_stall_ready", 32'(bit_ready), 32'd0);
        end
        data_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(bit_ready), 32'd1);
        tick();
        data_ready = 1'b0;
        bit_valid  = 1'b0;
        check_eq("bp_word_b", 32'(data_out), 32'h6);
        check_eq("bp_word_b_valid", 32'(data_valid), 32'd1);
        check_eq("bp_word_b_slot", 32'(slot_idx), 32'd0);
        data_ready = 1'b1;
        tick();
        check_eq("bp_drained", 32'(data_valid), 32'd0);

        // ---- back-to-back: 12 bits, three words, no stalls ----
        words[0] = 4'b0001;
        words[1] = 4'b1110;
        words[2] = 4'b1001;
        bit_valid = 1'b1;
        for (int j = 0; j < 12; j++) begin
            bit_in = words[j / 4][j % 4];
            #1;
            check_eq($sformatf("b2b_ready_%0d", j), 32'(bit_ready), 32'd1);
            tick();
            check_eq($sformatf("b2b_valid_%0d", j), 32'(data_valid), (j % 4 == 3) ? 32'd1 : 32'd0);
            if (j % 4 == 3) begin
                exp_b = words[j / 4];
                check_eq($sformatf("b2b_word_%0d", j / 4), 32'(data_out), 32'(exp_b));
            end
        end
        bit_valid = 1'b0;
        tick();

        // ---- clear: two bits, clear with a bit pending, then 1,1,0,0 ----
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_in    = 1'b0;
        tick();
        check_eq("clr_pre_slot", 32'(slot_idx), 32'd2);
        clear  = 1'b1;
        bit_in = 1'b1;
        #1;
        check_eq("clr_bit_ready", 32'(bit_ready), 32'd0);
        tick();
        clear = 1'b0;
        check_eq("clr_slot_idx", 32'(slot_idx), 32'd0);
        for (int j = 0; j < 4; j++) begin
            bit_in = (j < 2) ? 1'b1 : 1'b0;
            tick();
            if (j == 2) check_eq("clr_no_early_word", 32'(data_valid), 32'd0);
        end
        bit_valid = 1'b0;
        check_eq("clr_data_valid", 32'(data_valid), 32'd1);
        check_eq("clr_data_out", 32'(data_out), 32'h3);
        tick();

        // ---- async reset mid-word with a word held ----
        data_ready = 1'b0;
        bit_valid  = 1'b1;
        for (int j = 0; j < 6; j++) begin
            bit_in = 1'b1;
            tick();
        end
        check_eq("ar_pre_valid", 32'(data_valid), 32'd1);
        check_eq("ar_pre_slot", 32'(slot_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_data_valid", 32'(data_valid), 32'd0);
        check_eq("ar_data_out", 32'(data_out), 32'd0);
        check_eq("ar_slot_idx", 32'(slot_idx), 32'd0);
        check_eq("ar_bit_ready", 32'(bit_ready), 32'd0);
        tick();
        check_eq("ar_bit_ready_held", 32'(bit_ready), 32'd0);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        #1;
        check_eq("ar_release_ready", 32'(bit_ready), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
